gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Transmit-side MAC framer that turns a byte stream from the MAC transmit datapath into a GMII transmit frame for the PHY. It drives `tx_en`, `txd` and `tx_er` of the GMII interface. Each frame carries a preamble, SFD, payload, optional padding, CRC-32 FCS, and an enforced inter-frame gap. Payload underrun aborts the frame with `tx_er`.

## Interface
- `IFG_BYTES`, default 12: minimum idle cycles (`tx_en`=0) between frames; legal range 1..255.
- `MIN_PAYLOAD`, default 60: minimum bytes before FCS when padding is compiled in.
- `clk`  in  1  GMII transmit clock, 125 MHz; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  upstream byte valid.
- `s_data`  in  8  upstream payload byte (DA first).
- `s_last`  in  1  marks the final payload byte; qualified by `s_valid`.
- `s_ready`  out  1  framer accepts `s_data` this cycle.
- `tx_en`  out  1  GMII transmit enable.
- `txd`  out  8  GMII transmit data.
- `tx_er`  out  1  GMII transmit error.
- `busy`  out  1  high from frame start through the end of IFG.
- `abort`  out  1  one-cycle pulse when a frame is aborted on underrun.

## Operation
- A byte is accepted when `s_valid && s_ready`.
- `tx_en`, `txd`, `tx_er`, `busy` and `abort` are registered. `s_ready` is decoded from state.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE: `s_valid`=1 moves to PRE. This byte is not consumed.
- PRE: 7 cycles of `txd`=0x55, then SFD.
- SFD: `txd`=0xD5, then DATA.
- DATA: each accepted byte goes to `txd` and updates the CRC and an 11-bit payload counter. The counter saturates at 2047; there is no maximum-length check.
- DATA with `s_last` accepted: go to PAD if padding is compiled in and count < `MIN_PAYLOAD`, else go to FCS.
- DATA with `s_valid`=0 (underrun):
  - Drive one cycle of `tx_en`=1, `tx_er`=1, `txd`=0x00.
  - Pulse `abort`, send no FCS, then go to IFG.
- PAD: `txd`=0x00 is fed through the CRC until count = `MIN_PAYLOAD`, then FCS.
- FCS: 4 bytes of the complemented CRC, least significant byte first, then IFG.
  - CRC-32 uses the reflected polynomial 0xEDB88320, initialised to 0xFFFFFFFF at SFD.
  - Input bytes are processed LSB first.
- IFG: `tx_en`=0, `txd`=0x00 for `IFG_BYTES` cycles (8-bit down-counter), then IDLE.
- `tx_er`=0 in every state except the underrun cycle.

## Timing
- Reset values:
  - `tx_en`=0, `txd`=0x00, `tx_er`=0, `busy`=0, `abort`=0, `s_ready`=0.
  - State IDLE, CRC 0xFFFFFFFF, counters 0.
- Reset acts immediately at any time, including mid-frame. The line goes idle with no `tx_er` and no FCS.
- Let `s_valid` be sampled high in IDLE at cycle k. Then:
  - First `tx_en`=1 is at T=k+1.
  - Preamble occupies T..T+6 and the SFD is at T+7.
- `s_ready`=1 exactly in the SFD cycle and in DATA cycles.
- A byte handshaken at cycle j appears on `txd` at j+1. Payload is therefore gap-free when `s_valid` is held high.
- The cycle after the last payload or pad byte carries FCS byte 0.
- `tx_en` falls in the cycle after FCS byte 3.
- The next frame's `tx_en` can rise no earlier than `IFG_BYTES`+1 cycles after the fall, because IDLE costs one cycle.
- Underrun:
  - `s_valid`=0 in the cycle after a non-last handshake gives the error byte on `txd` in the following cycle.
  - `abort` pulses in that same cycle.
- A 1-byte payload is legal. `s_valid` and `s_last` high in the SFD cycle ends DATA after one byte.

## Configuration
- `GMII_TX_PAD_EN` defined: frames shorter than `MIN_PAYLOAD` bytes are zero-padded before FCS, and the pad bytes are included in the CRC.
- `GMII_TX_PAD_EN` undefined: PAD state absent. FCS follows the last payload byte directly, whatever the length.

## Test plan
- PAD undefined, payload ASCII "123456789", `s_valid` held high:
  - Required: `txd` = 7×0x55, 0xD5, 0x31..0x39, then 0x26, 0x39, 0xF4, 0xCB.
  - Required: `tx_en` high for exactly 21 cycles.
- PAD defined, 1-byte payload 0xAB with `s_last`:
  - Required: 0xAB, then 59×0x00, then 4 FCS bytes matching the reference CRC.
  - Required: `tx_en` high for 72 cycles.
- Back-to-back frames with `IFG_BYTES`=12:
  - Required: exactly 13 cycles of `tx_en`=0 between the last FCS byte and the next preamble.
  - Required: `s_ready`=0 throughout the gap.
- Underrun after 5 payload bytes:
  - Required: one cycle of `tx_er`=1, `txd`=0x00, with a single `abort` pulse.
  - Required: no FCS, then 12 idle cycles.
- `reset` asserted mid-payload:
  - Required: `tx_en`, `tx_er`, `busy` low and `txd`=0x00 immediately.
  - Required: after release, a new frame starts with a full 7-byte preamble.
- 1514-byte payload with PAD defined:
  - Required: no padding, FCS correct, counter not saturated.
  - Required: `tx_en` high for 1526 cycles.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, CRC-32 FCS, IFG.
// Define GMII_TX_PAD_EN to zero-pad short frames up to MIN_PAYLOAD bytes.
module gmii_tx_framer #(
  parameter int unsigned IFG_BYTES   = 12,
  parameter int unsigned MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_en,
  output logic [7:0] txd,
  output logic       tx_er,
  output logic       busy,
  output logic       abort
);

`ifdef GMII_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  localparam logic [7:0]  IFG_LD  = 8'(IFG_BYTES);
  localparam logic [10:0] MIN_LEN = 11'(MIN_PAYLOAD);
  localparam logic [31:0] POLY    = 32'hEDB88320;

  typedef enum logic [2:0] {
    IDLE, PRE, SFD, DATA, PAD, FCS, IFG
  } state_t;

  state_t      state_q;
  logic [31:0] crc_q;
  logic [10:0] cnt_q;
  logic [7:0]  ifg_q;
  logic [2:0]  sub_q;

  logic [31:0] crc_d;
  logic [10:0] cnt_d;
  logic [7:0]  crc_in;
  logic [31:0] crc_n;
  logic [7:0]  fcs_byte;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  assign s_ready  = (state_q == SFD) || (state_q == DATA);
  assign crc_in   = (state_q == PAD) ? 8'h00 : s_data;
  assign crc_d    = crc_byte(crc_q, crc_in);
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 11'd1;
  assign crc_n    = ~crc_q;
  assign fcs_byte = crc_n[{sub_q[1:0], 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      crc_q   <= '1;
      cnt_q   <= '0;
      ifg_q   <= '0;
      sub_q   <= '0;
      tx_en   <= 1'b0;
      txd     <= 8'h00;
      tx_er   <= 1'b0;
      busy    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      tx_er <= 1'b0;
      abort <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s_valid) begin
            state_q <= PRE;
            tx_en   <= 1'b1;
            txd     <= 8'h55;
            busy    <= 1'b1;
            sub_q   <= 3'd1;
          end
        end
        PRE: begin
          if (sub_q == 3'd7) begin
            state_q <= SFD;
            txd     <= 8'hD5;
            crc_q   <= '1;
            cnt_q   <= '0;
          end else begin
            txd   <= 8'h55;
            sub_q <= sub_q + 3'd1;
          end
        end
        SFD, DATA: begin
          if (s_valid) begin
            txd   <= s_data;
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            sub_q <= 3'd0;
            if (!s_last)
              state_q <= DATA;
            else if (PAD_ON && (cnt_d < MIN_LEN))
              state_q <= PAD;
            else
              state_q <= FCS;
          end else begin
            // Underrun: one error byte, no FCS.
            tx_er   <= 1'b1;
            txd     <= 8'h00;
            abort   <= 1'b1;
            ifg_q   <= IFG_LD;
            state_q <= IFG;
          end
        end
        PAD: begin
          txd   <= 8'h00;
          crc_q <= crc_d;
          cnt_q <= cnt_d;
          if (cnt_d >= MIN_LEN)
            state_q <= FCS;
        end
        FCS: begin
          txd   <= fcs_byte;
          sub_q <= sub_q + 3'd1;
          if (sub_q[1:0] == 2'd3) begin
            ifg_q   <= IFG_LD;
            state_q <= IFG;
          end
        end
        IFG: begin
          tx_en <= 1'b0;
          txd   <= 8'h00;
          if (ifg_q == 8'd0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            ifg_q <= ifg_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: framing, CRC, pad, IFG, underrun, reset.
// Expectations follow GMII_TX_PAD_EN when it is defined for the build.
module tb_gmii_tx_framer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       s_ready, tx_en, tx_er, busy, abort;
  logic [7:0] txd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] pay [0:2047];
  logic [7:0] cap [$];
  logic [7:0] exp_q [$];
  int en_cycles, er_cycles, abort_cnt, abort_er;
  int first_en, first_rdy;
  int gap_run, last_gap, rdy_gap;
  bit seen, in_gap;

`ifdef GMII_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  gmii_tx_framer dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .tx_en   (tx_en),
    .txd     (txd),
    .tx_er   (tx_er),
    .busy    (busy),
    .abort   (abort)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_en) begin
      cap.push_back(txd);
      en_cycles++;
      if (first_en < 0) first_en = cyc;
      if (in_gap) begin
        last_gap = gap_run;
        in_gap = 1'b0;
      end
      seen = 1'b1;
    end else if (seen) begin
      if (!in_gap) begin
        in_gap = 1'b1;
        gap_run = 0;
      end
      gap_run++;
      if (s_ready) rdy_gap++;
    end
    if (s_ready && first_rdy < 0) first_rdy = cyc;
    if (tx_er) er_cycles++;
    if (abort) abort_cnt++;
    if (abort && tx_er) abort_er++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    cap.delete();
    exp_q.delete();
    en_cycles = 0; er_cycles = 0;
    abort_cnt = 0; abort_er = 0;
    first_en = -1; first_rdy = -1;
    gap_run = 0; last_gap = -1; rdy_gap = 0;
    seen = 1'b0; in_gap = 1'b0;
  endtask

  function automatic logic [31:0] ref_fcs(input int len, input int total);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total; i++) begin
      b = (i < len) ? pay[i] : 8'h00;
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(input int len);
    int total;
    logic [31:0] f;
    total = (PAD && len < 60) ? 60 : len;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < total; i++)
      exp_q.push_back((i < len) ? pay[i] : 8'h00);
    f = ref_fcs(len, total);
    exp_q.push_back(f[7:0]);
    exp_q.push_back(f[15:8]);
    exp_q.push_back(f[23:16]);
    exp_q.push_back(f[31:24]);
  endtask

  function automatic int first_diff();
    if (cap.size() != exp_q.size()) return -2;
    foreach (cap[i]) if (cap[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic drive(input int len, input int stop_at, output bit ok);
    int i;
    int n;
    bit hs;
    i = 0;
    n = 0;
    s_valid = 1'b1;
    s_data = pay[0];
    s_last = (len == 1);
    while (i < len && n < 5000) begin
      @(negedge clk);
      hs = s_ready;
      n++;
      @(posedge clk);
      #1;
      if (hs) begin
        i++;
        if (i == stop_at || i == len) begin
          s_valid = 1'b0;
          s_last = 1'b0;
          s_data = 8'h00;
          break;
        end
        s_data = pay[i];
        s_last = (i == len - 1);
      end
    end
    ok = (i == len) || (i == stop_at);
    if (!ok) begin
      s_valid = 1'b0;
      s_last = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || tx_en) && n < 4000);
    tests++;
    if (busy || tx_en) begin
      fails++;
      $display("FAIL %s done: busy=%0b tx_en=%0b after %0d cycles, want idle",
               name, busy, tx_en, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (tx_en !== 1'b0) begin fails++; $display("FAIL rst tx_en: got %0b want 0", tx_en); end
    tests++;
    if (txd !== 8'h00) begin fails++; $display("FAIL rst txd: got %h want 00", txd); end
    tests++;
    if (tx_er !== 1'b0) begin fails++; $display("FAIL rst tx_er: got %0b want 0", tx_er); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL rst busy: got %0b want 0", busy); end
    tests++;
    if (abort !== 1'b0) begin fails++; $display("FAIL rst abort: got %0b want 0", abort); end
    tests++;
    if (s_ready !== 1'b0) begin fails++; $display("FAIL rst s_ready: got %0b want 0", s_ready); end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (tx_en !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: tx_en=%0b busy=%0b want 0 0", tx_en, busy);
    end
  endtask

  task automatic test_crc_frame();
    bit ok;
    int k, d;
    logic [31:0] fcs;
    string s;
    s = "123456789";
    for (int i = 0; i < 9; i++) pay[i] = s[i];
    clear_mon();
    @(posedge clk);
    #1 k = cyc;
    drive(9, 0, ok);
    wait_done("crc");
    build_exp(9);
    tests++;
    if (!ok) begin fails++; $display("FAIL crc handshake: got ok=%0b want 1", ok); end
    tests++;
    if (first_en != k + 1) begin
      fails++;
      $display("FAIL crc first_tx_en: got cycle %0d want %0d", first_en, k + 1);
    end
    tests++;
    if (first_rdy != k + 8) begin
      fails++;
      $display("FAIL crc sfd_ready: got cycle %0d want %0d", first_rdy, k + 8);
    end
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL crc bytes: diff at %0d got_len=%0d want_len=%0d", d, cap.size(), exp_q.size());
    end
    tests++;
    if (en_cycles != (PAD ? 72 : 21)) begin
      fails++;
      $display("FAIL crc tx_en_len: got %0d want %0d", en_cycles, PAD ? 72 : 21);
    end
    tests++;
    if (er_cycles != 0) begin fails++; $display("FAIL crc tx_er: got %0d cycles want 0", er_cycles); end
`ifndef GMII_TX_PAD_EN
    fcs = 32'h0;
    if (cap.size() >= 4)
      fcs = {cap[cap.size()-1], cap[cap.size()-2], cap[cap.size()-3], cap[cap.size()-4]};
    tests++;
    if (fcs !== 32'hCBF43926) begin
      fails++;
      $display("FAIL crc check_value: got %h want cbf43926", fcs);
    end
`else
    fcs = 32'h0;
`endif
  endtask

  task automatic test_pad_1byte();
    bit ok;
    int d;
    pay[0] = 8'hAB;
    clear_mon();
    @(posedge clk);
    #1 drive(1, 0, ok);
    wait_done("pad1");
    build_exp(1);
    d = first_diff();
    tests++;
    if (!ok || d != -1) begin
      fails++;
      $display("FAIL pad1 bytes: ok=%0b diff at %0d got_len=%0d want_len=%0d",
               ok, d, cap.size(), exp_q.size());
    end
    tests++;
    if (en_cycles != (PAD ? 72 : 13)) begin
      fails++;
      $display("FAIL pad1 tx_en_len: got %0d want %0d", en_cycles, PAD ? 72 : 13);
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int d, flen;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    clear_mon();
    @(posedge clk);
    #1 drive(4, 0, ok1);
    drive(4, 0, ok2);
    wait_done("b2b");
    build_exp(4);
    build_exp(4);
    flen = PAD ? 72 : 16;
    d = first_diff();
    tests++;
    if (!ok1 || !ok2 || d != -1) begin
      fails++;
      $display("FAIL b2b bytes: ok=%0b%0b diff at %0d got_len=%0d want_len=%0d",
               ok1, ok2, d, cap.size(), exp_q.size());
    end
    tests++;
    if (last_gap != 13) begin fails++; $display("FAIL b2b gap: got %0d want 13", last_gap); end
    tests++;
    if (rdy_gap != 0) begin fails++; $display("FAIL b2b ready_in_gap: got %0d want 0", rdy_gap); end
    tests++;
    if (en_cycles != 2 * flen) begin
      fails++;
      $display("FAIL b2b tx_en_len: got %0d want %0d", en_cycles, 2 * flen);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    int d, bad;
    for (int i = 0; i < 10; i++) pay[i] = 8'hA0 + 8'(i);
    clear_mon();
    @(posedge clk);
    #1 drive(10, 5, ok);
    @(negedge clk);
    tests++;
    if (txd !== 8'hA4 || tx_er !== 1'b0) begin
      fails++;
      $display("FAIL urun last_byte: got txd=%h er=%0b want a4 0", txd, tx_er);
    end
    @(negedge clk);
    tests++;
    if (tx_en !== 1'b1 || tx_er !== 1'b1 || txd !== 8'h00 || abort !== 1'b1) begin
      fails++;
      $display("FAIL urun err_byte: got en=%0b er=%0b txd=%h abort=%0b want 1 1 00 1",
               tx_en, tx_er, txd, abort);
    end
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || tx_er !== 1'b0) bad++;
    end
    tests++;
    if (!ok || bad != 0) begin
      fails++;
      $display("FAIL urun idle: ok=%0b got %0d non-idle cycles want 0", ok, bad);
    end
    wait_done("urun");
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 5; i++) exp_q.push_back(pay[i]);
    exp_q.push_back(8'h00);
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++;
      $display("FAIL urun bytes: diff at %0d got_len=%0d want_len=%0d", d, cap.size(), exp_q.size());
    end
    tests++;
    if (er_cycles != 1 || abort_cnt != 1 || abort_er != 1) begin
      fails++;
      $display("FAIL urun pulses: got er=%0d abort=%0d both=%0d want 1 1 1",
               er_cycles, abort_cnt, abort_er);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d;
    clear_mon();
    s_data = 8'h5A;
    s_last = 1'b0;
    @(posedge clk);
    #1 s_valid = 1'b1;
    repeat (12) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    tests++;
    if (tx_en !== 1'b0 || tx_er !== 1'b0 || busy !== 1'b0 || txd !== 8'h00 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got en=%0b er=%0b busy=%0b txd=%h rdy=%0b want all 0",
               tx_en, tx_er, busy, txd, s_ready);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
    clear_mon();
    @(posedge clk);
    #1 drive(3, 0, ok);
    wait_done("post_reset");
    build_exp(3);
    d = first_diff();
    tests++;
    if (!ok || d != -1) begin
      fails++;
      $display("FAIL post_reset bytes: ok=%0b diff at %0d got_len=%0d want_len=%0d",
               ok, d, cap.size(), exp_q.size());
    end
  endtask

  task automatic test_long();
    bit ok;
    int d;
    for (int i = 0; i < 1514; i++) pay[i] = 8'(i * 13 + 7);
    clear_mon();
    @(posedge clk);
    #1 drive(1514, 0, ok);
    wait_done("long");
    build_exp(1514);
    d = first_diff();
    tests++;
    if (!ok || d != -1) begin
      fails++;
      $display("FAIL long bytes: ok=%0b diff at %0d got_len=%0d want_len=%0d",
               ok, d, cap.size(), exp_q.size());
    end
    tests++;
    if (en_cycles != 1526) begin
      fails++;
      $display("FAIL long tx_en_len: got %0d want 1526", en_cycles);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_crc_frame();
    test_pad_1byte();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    test_long();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
